// File: rtl/imem_loader.sv
// Byte-stream loader for instruction memory. Packs incoming bytes big-endian into
// 32-bit words (first byte in the MSB lane) and issues one word write per word,
// starting at a word-aligned base address.
module imem_loader #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned PC    = 32,
    parameter int unsigned DEPTH = 1024
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic [PC-1:0]      i_base_addr,
    input  logic [PC-1:0]      i_byte_count,
    input  logic               i_in_valid,
    input  logic [WIDTH-1:0]   i_in_data,
    output logic               o_in_ready,
    output logic               o_wr_en,
    output logic [PC-1:0]      o_wr_addr,
    output logic [4*WIDTH-1:0] o_wr_data,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_error
);

    localparam int unsigned WordW = 4 * WIDTH;
    localparam int unsigned SumW  = PC + 1;

    typedef enum logic [1:0] {StIdle, StRecv, StWrite, StDone} state_e;

    state_e            r_state;
    logic [WordW-1:0]  r_buf;
    logic [1:0]        r_idx;
    logic [PC-1:0]     r_remaining;
    logic [PC-1:0]     r_addr;
    logic              r_wr_en;
    logic [PC-1:0]     r_wr_addr;
    logic [WordW-1:0]  r_wr_data;
    logic              r_error;

    state_e            w_state_d;
    logic [WordW-1:0]  w_buf_d;
    logic [1:0]        w_idx_d;
    logic [PC-1:0]     w_remaining_d;
    logic [PC-1:0]     w_addr_d;
    logic              w_wr_en_d;
    logic [PC-1:0]     w_wr_addr_d;
    logic [WordW-1:0]  w_wr_data_d;
    logic              w_error_d;

    logic [SumW-1:0]   w_end_addr;
    logic              w_params_bad;

    // Extra bit on the end address so base+count can never wrap past DEPTH.
    assign w_end_addr   = {1'b0, i_base_addr} + {1'b0, i_byte_count};
    assign w_params_bad = (i_base_addr[1:0] != 2'b00) || (w_end_addr > SumW'(DEPTH));

    // Next-state and datapath decode for the load sequence.
    always_comb begin
        w_state_d     = r_state;
        w_buf_d       = r_buf;
        w_idx_d       = r_idx;
        w_remaining_d = r_remaining;
        w_addr_d      = r_addr;
        w_wr_en_d     = 1'b0;
        w_wr_addr_d   = r_wr_addr;
        w_wr_data_d   = r_wr_data;
        w_error_d     = r_error;

        unique case (r_state)
            StIdle: begin
                if (i_start) begin
                    if (w_params_bad) begin
                        w_error_d = 1'b1;
                    end else if (i_byte_count == '0) begin
                        w_error_d = 1'b0;
                        w_state_d = StDone;
                    end else begin
                        w_error_d     = 1'b0;
                        w_addr_d      = i_base_addr;
                        w_remaining_d = i_byte_count;
                        w_buf_d       = '0;
                        w_idx_d       = 2'd0;
                        w_state_d     = StRecv;
                    end
                end
            end
            StRecv: begin
                if (i_in_valid) begin
                    unique case (r_idx)
                        2'd0: w_buf_d[WordW-1 -: WIDTH]     = i_in_data;
                        2'd1: w_buf_d[3*WIDTH-1 -: WIDTH]   = i_in_data;
                        2'd2: w_buf_d[2*WIDTH-1 -: WIDTH]   = i_in_data;
                        2'd3: w_buf_d[WIDTH-1 -: WIDTH]     = i_in_data;
                        default: w_buf_d = r_buf;
                    endcase
                    w_idx_d       = r_idx + 2'd1;
                    w_remaining_d = r_remaining - PC'(1);
                    // Load the write port now so the strobe is registered yet lands
                    // in the WRITE cycle itself.
                    if ((r_idx == 2'd3) || (r_remaining == PC'(1))) begin
                        w_state_d   = StWrite;
                        w_wr_en_d   = 1'b1;
                        w_wr_addr_d = r_addr;
                        w_wr_data_d = w_buf_d;
                    end
                end
            end
            StWrite: begin
                w_addr_d  = r_addr + PC'(4);
                w_buf_d   = '0;
                w_idx_d   = 2'd0;
                w_state_d = (r_remaining == '0) ? StDone : StRecv;
            end
            StDone: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_buf       <= '0;
            r_idx       <= 2'd0;
            r_remaining <= '0;
            r_addr      <= '0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_error     <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_buf       <= w_buf_d;
            r_idx       <= w_idx_d;
            r_remaining <= w_remaining_d;
            r_addr      <= w_addr_d;
            r_wr_en     <= w_wr_en_d;
            r_wr_addr   <= w_wr_addr_d;
            r_wr_data   <= w_wr_data_d;
            r_error     <= w_error_d;
        end
    end

    // Status outputs decoded straight from the state register.
    always_comb begin
        o_in_ready = (r_state == StRecv);
        o_busy     = (r_state == StRecv) || (r_state == StWrite);
        o_done     = (r_state == StDone);
        o_wr_en    = r_wr_en;
        o_wr_addr  = r_wr_addr;
        o_wr_data  = r_wr_data;
        o_error    = r_error;
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus pushes expected writes/done pulses,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_imem_loader;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_start = 1'b0;
    logic [31:0] i_base_addr = '0;
    logic [31:0] i_byte_count = '0;
    logic        i_in_valid = 1'b0;
    logic [7:0]  i_in_data = '0;
    logic        o_in_ready;
    logic        o_wr_en;
    logic [31:0] o_wr_addr;
    logic [31:0] o_wr_data;
    logic        o_busy;
    logic        o_done;
    logic        o_error;

    imem_loader #(
        .WIDTH (8),
        .PC    (32),
        .DEPTH (1024)
    ) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_start      (i_start),
        .i_base_addr  (i_base_addr),
        .i_byte_count (i_byte_count),
        .i_in_valid   (i_in_valid),
        .i_in_data    (i_in_data),
        .o_in_ready   (o_in_ready),
        .o_wr_en      (o_wr_en),
        .o_wr_addr    (o_wr_addr),
        .o_wr_data    (o_wr_data),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_error      (o_error)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        bit          is_done;
        bit          after_wr;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    bit   prev_wr_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_wr(input logic [31:0] addr, input logic [31:0] data);
        exp_t e;
        e.is_done = 1'b0; e.after_wr = 1'b0; e.addr = addr; e.data = data;
        sb_q.push_back(e);
    endtask

    task automatic push_done(input bit after_wr);
        exp_t e;
        e.is_done = 1'b1; e.after_wr = after_wr; e.addr = '0; e.data = '0;
        sb_q.push_back(e);
    endtask

    // Monitor: every write strobe and done pulse must match the head of the scoreboard.
    always @(negedge i_clk) begin
        exp_t e;
        if (o_wr_en) begin
            check("ready_low_in_write", 32'(o_in_ready), 32'd0);
            if (sb_q.size() == 0) begin
                check("unexpected_write", o_wr_addr, 32'hFFFF_FFFF);
            end else begin
                e = sb_q.pop_front();
                check("kind_write", 32'(e.is_done), 32'd0);
                check("wr_addr", o_wr_addr, e.addr);
                check("wr_data", o_wr_data, e.data);
            end
        end
        if (o_done) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("kind_done", 32'(e.is_done), 32'd1);
                if (e.after_wr) check("done_after_write", 32'(prev_wr_en), 32'd1);
                check("busy_low_in_done", 32'(o_busy), 32'd0);
            end
        end
        prev_wr_en = o_wr_en;
    end

    // All stimulus tasks are entered and left at posedge+1.
    task automatic start_load(input logic [31:0] base, input logic [31:0] cnt);
        i_start = 1'b1;
        i_base_addr = base;
        i_byte_count = cnt;
        @(posedge i_clk); #1;
        i_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit acc = 1'b0;
        i_in_valid = 1'b1;
        i_in_data = b;
        for (int t = 0; t < 50; t++) begin
            @(negedge i_clk);
            if (o_in_ready) begin
                acc = 1'b1;
                break;
            end
        end
        @(posedge i_clk); #1;
        i_in_valid = 1'b0;
        if (!acc) check("byte_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(negedge i_clk);
            if (o_done) begin
                seen = 1'b1;
                break;
            end
        end
        @(posedge i_clk); #1;
        check(name, 32'(seen), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] t1 [8];
        t1 = '{8'h8C, 8'h01, 8'h00, 8'h04, 8'hAC, 8'h22, 8'h00, 8'h08};

        // Reset state
        i_rst_n = 1'b0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        check("rst_wr_en", 32'(o_wr_en), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        check("rst_error", 32'(o_error), 32'd0);
        check("rst_ready", 32'(o_in_ready), 32'd0);
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;

        // 1: two full words back to back
        push_wr(32'd0, 32'h8C01_0004);
        push_wr(32'd4, 32'hAC22_0008);
        push_done(1'b1);
        start_load(32'd0, 32'd8);
        for (int i = 0; i < 8; i++) send_byte(t1[i]);
        wait_done("t1_done");

        // 2: partial last word padded with zeros
        push_wr(32'd16, 32'h1112_1314);
        push_wr(32'd20, 32'h1516_0000);
        push_done(1'b1);
        start_load(32'd16, 32'd6);
        for (int i = 0; i < 6; i++) send_byte(8'h11 + 8'(i));
        wait_done("t2_done");

        // 3: parameter rejection and recovery
        start_load(32'd2, 32'd4);
        @(negedge i_clk);
        check("t3_misalign_error", 32'(o_error), 32'd1);
        check("t3_misalign_busy", 32'(o_busy), 32'd0);
        check("t3_misalign_ready", 32'(o_in_ready), 32'd0);
        @(posedge i_clk); #1;
        push_done(1'b0);
        start_load(32'd0, 32'd0);
        @(negedge i_clk);
        check("t3_clear_error", 32'(o_error), 32'd0);
        @(posedge i_clk); #1;
        start_load(32'd1020, 32'd8);
        @(negedge i_clk);
        check("t3_overrun_error", 32'(o_error), 32'd1);
        check("t3_overrun_busy", 32'(o_busy), 32'd0);
        @(posedge i_clk); #1;
        push_wr(32'd1020, 32'h3132_3334);
        push_done(1'b1);
        start_load(32'd1020, 32'd4);
        @(negedge i_clk);
        check("t3_edge_error", 32'(o_error), 32'd0);
        check("t3_edge_busy", 32'(o_busy), 32'd1);
        @(posedge i_clk); #1;
        for (int i = 0; i < 4; i++) send_byte(8'h31 + 8'(i));
        wait_done("t3_done");

        // 4: valid gaps over 12 bytes
        push_wr(32'd100, 32'hA0A1_A2A3);
        push_wr(32'd104, 32'hA4A5_A6A7);
        push_wr(32'd108, 32'hA8A9_AAAB);
        push_done(1'b1);
        start_load(32'd100, 32'd12);
        for (int i = 0; i < 12; i++) begin
            int g;
            g = $urandom_range(0, 3);
            if (g != 0) begin
                repeat (g) @(posedge i_clk);
                #1;
            end
            send_byte(8'hA0 + 8'(i));
        end
        wait_done("t4_done");

        // 5: reset in the middle of a word
        start_load(32'd200, 32'd8);
        send_byte(8'hDE);
        send_byte(8'hAD);
        i_rst_n = 1'b0;
        @(posedge i_clk); #1;
        @(negedge i_clk);
        check("t5_wr_en", 32'(o_wr_en), 32'd0);
        check("t5_busy", 32'(o_busy), 32'd0);
        check("t5_ready", 32'(o_in_ready), 32'd0);
        check("t5_wr_addr", o_wr_addr, 32'd0);
        check("t5_wr_data", o_wr_data, 32'd0);
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        push_wr(32'd0, 32'h0102_0304);
        push_done(1'b1);
        start_load(32'd0, 32'd4);
        for (int i = 0; i < 4; i++) send_byte(8'h01 + 8'(i));
        wait_done("t5_done");

        // 6: zero-length load, then start ignored while receiving
        push_done(1'b0);
        start_load(32'd8, 32'd0);
        @(negedge i_clk);
        check("t6_zero_done", 32'(o_done), 32'd1);
        check("t6_zero_wr_en", 32'(o_wr_en), 32'd0);
        @(posedge i_clk); #1;
        push_wr(32'd36, 32'h5A5B_5C5D);
        push_done(1'b1);
        start_load(32'd36, 32'd4);
        send_byte(8'h5A);
        i_start = 1'b1;
        i_base_addr = 32'd2;
        i_byte_count = 32'd4;
        send_byte(8'h5B);
        send_byte(8'h5C);
        i_start = 1'b0;
        send_byte(8'h5D);
        wait_done("t6_done");
        check("t6_error_untouched", 32'(o_error), 32'd0);

        repeat (3) @(posedge i_clk);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
